jt51_mixacc: RTL and testbench

//  Output accumulator directly downstream of the operator pipeline. Consumes one signed
//  14-bit operator sample per cen slot (32 slots/frame = 8 ch x 4 ops) and sums carrier

---
 rtl/jt51_mixacc_pkg.sv | 39 +++
 rtl/jt51_sh.sv | 27 ++
 rtl/jt51_mixacc.sv | 93 +++++++++
 tb/tb_jt51_mixacc.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/jt51_mixacc_pkg.sv
// Shared constants and helpers for the operator output accumulator.
// Slot groups, carrier selection per connection algorithm, output saturation.
package jt51_mixacc_pkg;

  localparam int unsigned MIX_ACC_W = 19;
  localparam int unsigned MIX_OUT_W = 16;

  localparam logic [1:0] GRP_M1 = 2'd0;
  localparam logic [1:0] GRP_M2 = 2'd1;
  localparam logic [1:0] GRP_C1 = 2'd2;
  localparam logic [1:0] GRP_C2 = 2'd3;

  localparam logic [4:0] SLOT_FIRST_C2 = 5'd24;
  localparam logic [4:0] SLOT_LAST     = 5'd31;

  function automatic logic is_carrier(input logic [1:0] grp, input logic [2:0] con);
    logic car;
    unique case (grp)
      GRP_C2:  car = 1'b1;
      GRP_C1:  car = (con >= 3'd4);
      GRP_M2:  car = (con >= 3'd5);
      default: car = (con == 3'd7);
    endcase
    return car;
  endfunction

  // Clamp a running total into the signed output range.
  function automatic logic signed [MIX_OUT_W-1:0] sat(input logic signed [MIX_ACC_W-1:0] val);
    logic signed [MIX_ACC_W-1:0] hi, lo;
    logic signed [MIX_ACC_W-1:0] clamped;
    hi = MIX_ACC_W'((1 << (MIX_OUT_W - 1)) - 1);
    lo = -hi - MIX_ACC_W'(1);
    if (val > hi)      clamped = hi;
    else if (val < lo) clamped = lo;
    else               clamped = val;
    return clamped[MIX_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/jt51_sh.sv
// Generic cen-gated shift register with synchronous clear; drop is the value
// written Stages enabled cycles earlier.
module jt51_sh #(
  parameter int unsigned Width  = 16,
  parameter int unsigned Stages = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] drop
);

  logic [Width-1:0] bits_q [Stages];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Stages); i++) bits_q[i] <= '0;
    end else if (cen) begin
      bits_q[0] <= din;
      for (int i = 1; i < int'(Stages); i++) bits_q[i] <= bits_q[i-1];
    end
  end

  assign drop = bits_q[Stages-1];

endmodule

// File: rtl/jt51_mixacc.sv
// Per-channel carrier accumulation and stereo mixing of the operator stream;
// emits one saturated L/R sample per 32-slot frame.
module jt51_mixacc
  import jt51_mixacc_pkg::*;
#(
  parameter int unsigned ACC_W = MIX_ACC_W,
  parameter int unsigned OUT_W = MIX_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    zero,
  input  logic signed [13:0]      op_in,
  input  logic [2:0]              con_in,
  input  logic [1:0]              rl_in,
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    sample
);

  logic [4:0] s_q;
  logic       locked_q;
  logic [4:0] slot;
  logic [1:0] grp;

  assign slot = zero ? 5'd0 : s_q;
  assign grp  = slot[4:3];

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      locked_q <= 1'b0;
    end else if (cen) begin
      s_q <= zero ? 5'd1 : s_q + 5'd1;
      if (zero) locked_q <= 1'b1;
    end
  end

  logic signed [15:0] term, acc_prev, acc_sum, acc_next;

  assign term     = is_carrier(grp, con_in) ? 16'(op_in) : 16'sd0;
  assign acc_sum  = acc_prev + term;
  // M1 slots start a fresh channel sum; stale ring data from earlier frames is dropped.
  assign acc_next = (grp == GRP_M1) ? term : acc_sum;

  jt51_sh #(
    .Width (16),
    .Stages(8)
  ) u_acc_ring (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .din (acc_next),
    .drop(acc_prev)
  );

  logic signed [ACC_W-1:0] l_q, r_q, chsum_ext, l_base, r_base, l_fin, r_fin;
  logic signed [OUT_W-1:0] left_q, right_q;
  logic                    sample_q;

  assign chsum_ext = ACC_W'(acc_sum);
  // Totals reload on the first C2 slot instead of needing a separate clear.
  assign l_base    = (slot == SLOT_FIRST_C2) ? '0 : l_q;
  assign r_base    = (slot == SLOT_FIRST_C2) ? '0 : r_q;
  assign l_fin     = l_base + (rl_in[0] ? chsum_ext : '0);
  assign r_fin     = r_base + (rl_in[1] ? chsum_ext : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q      <= '0;
      r_q      <= '0;
      left_q   <= '0;
      right_q  <= '0;
      sample_q <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      if (cen && grp == GRP_C2) begin
        l_q <= l_fin;
        r_q <= r_fin;
      end
      if (cen && slot == SLOT_LAST && locked_q) begin
        left_q   <= sat(l_fin);
        right_q  <= sat(r_fin);
        sample_q <= 1'b1;
      end
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_jt51_mixacc.sv
// Directed bench for jt51_mixacc: full frames with hand-computed L/R results,
// resync, unlocked operation and mid-frame reset.
module tb_jt51_mixacc;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cen = 1'b0;
  logic               zero = 1'b0;
  logic signed [13:0] op_in = '0;
  logic [2:0]         con_in = '0;
  logic [1:0]         rl_in = '0;
  logic signed [15:0] left, right;
  logic               sample;

  int n_chk  = 0;
  int n_pass = 0;
  int n_samp = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (sample) n_samp <= n_samp + 1;

  jt51_mixacc dut (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .zero  (zero),
    .op_in (op_in),
    .con_in(con_in),
    .rl_in (rl_in),
    .left  (left),
    .right (right),
    .sample(sample)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // One enabled slot, preceded by gap idle clocks; returns #1 after the cen edge.
  task automatic slot(input logic z, input int op, input logic [2:0] con,
                      input logic [1:0] rl, input int gap);
    repeat (gap) begin
      cen = 1'b0;
      @(posedge clk);
      #1;
    end
    zero   = z;
    op_in  = 14'(op);
    con_in = con;
    rl_in  = rl;
    cen    = 1'b1;
    @(posedge clk);
    #1;
    cen  = 1'b0;
    zero = 1'b0;
  endtask

  // Slots first..last of a frame; zero on slot 0. ch0_only zeroes op_in on other channels.
  task automatic frame(input int first, input int last, input int op, input logic [2:0] con,
                       input logic [1:0] rl, input bit ch0_only, input int gap);
    for (int i = first; i <= last; i++)
      slot(i == 0, (ch0_only && (i % 8) != 0) ? 0 : op, con, rl, gap);
  endtask

  task automatic check_frame(input string tag, input int exp_l, input int exp_r);
    check({tag, " sample"}, int'(sample), 1);
    check({tag, " left"}, int'(left), exp_l);
    check({tag, " right"}, int'(right), exp_r);
    @(posedge clk);
    #1;
    check({tag, " pulse width"}, int'(sample), 0);
  endtask

  int cnt0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst left", int'(left), 0);
    check("rst right", int'(right), 0);
    check("rst sample", int'(sample), 0);
    rst = 1'b0;

    // 1: every op is a carrier, both sides
    cnt0 = n_samp;
    frame(0, 31, 100, 3'd7, 2'b11, 1'b0, 0);
    check_frame("t1", 3200, 3200);
    check("t1 one pulse", n_samp - cnt0, 1);

    // 2: C2 only, left; saturates high
    frame(0, 31, 8191, 3'd0, 2'b01, 1'b0, 0);
    check_frame("t2", 32767, 0);

    // 3: C1+C2, right; saturates low, then in range
    frame(0, 31, -8192, 3'd4, 2'b10, 1'b0, 0);
    check_frame("t3a", 0, -32768);
    frame(0, 31, -1000, 3'd4, 2'b10, 1'b0, 0);
    check_frame("t3b", 0, -16000);

    // 4: sparse cen, only ch0 nonzero, M2+C1+C2
    cnt0 = n_samp;
    frame(0, 31, 10, 3'd5, 2'b01, 1'b1, 2);
    check_frame("t4a", 30, 0);
    frame(0, 31, 10, 3'd5, 2'b01, 1'b1, 2);
    check_frame("t4b", 30, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4 hold left", int'(left), 30);
    check("t4 idle sample", int'(sample), 0);
    check("t4 sample count", n_samp - cnt0, 2);

    // 5: zero reasserted at slot 13 discards the broken frame
    cnt0 = n_samp;
    frame(0, 12, 5000, 3'd7, 2'b11, 1'b0, 0);
    check("t5 no early pulse", n_samp - cnt0, 0);
    check("t5 held left", int'(left), 30);
    frame(0, 31, 100, 3'd7, 2'b11, 1'b0, 0);
    check_frame("t5", 3200, 3200);
    check("t5 sample count", n_samp - cnt0, 1);

    // 6a: unlocked after reset, no zero for 64 slots
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    cnt0 = n_samp;
    for (int i = 0; i < 64; i++) slot(1'b0, 100, 3'd7, 2'b11, 0);
    check("t6 unlocked pulses", n_samp - cnt0, 0);
    check("t6 unlocked left", int'(left), 0);
    check("t6 unlocked right", int'(right), 0);

    // 6b: lock, then reset at slot 20 of the next frame
    frame(0, 31, 100, 3'd7, 2'b11, 1'b0, 0);
    check_frame("t6 lock", 3200, 3200);
    frame(0, 19, 100, 3'd7, 2'b11, 1'b0, 0);
    rst = 1'b1;
    slot(1'b0, 100, 3'd7, 2'b11, 0);
    rst = 1'b0;
    check("t6 rst left", int'(left), 0);
    check("t6 rst right", int'(right), 0);
    check("t6 rst sample", int'(sample), 0);
    cnt0 = n_samp;
    for (int i = 0; i < 40; i++) slot(1'b0, 100, 3'd7, 2'b11, 0);
    check("t6 post-rst pulses", n_samp - cnt0, 0);
    frame(0, 31, 50, 3'd7, 2'b01, 1'b0, 0);
    check_frame("t6 relock", 1600, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
